pacman_key_event_queue: RTL



---
 rtl/pacman_key_event_queue_if.sv | 11 +
 rtl/pacman_key_event_queue.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pacman_key_event_queue_if.sv
// GPIO-facing signal bundle of the key event queue: raw keys and software
// controls in, packed status word out.
interface pacman_key_event_queue_if;
    logic [3:0]  key_n;
    logic        ack_toggle;
    logic        ovf_clr;
    logic [31:0] status;

    modport master (output key_n, ack_toggle, ovf_clr, input status);
    modport slave  (input key_n, ack_toggle, ovf_clr, output status);
endinterface

// File: rtl/pacman_key_event_queue.sv
// Push-button debouncer feeding a small key-press event FIFO that software
// reads and pops through GPIO (toggle-to-pop, sticky overflow).
module pacman_key_event_queue #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    pacman_key_event_queue_if.slave io_bus
);
    localparam int          PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       r_sync1;
    logic [3:0]       r_sync2;
    logic [3:0]       r_stable;
    logic [3:0]       r_stable_d;
    logic [3:0]       r_pending;
    logic [19:0]      r_db_cnt [4];
    logic [7:0]       r_seq;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_ack_prev;
    logic             r_ovf_clr_prev;
    logic [31:0]      r_status;
    logic [1:0]       r_mem_idx [FIFO_DEPTH];
    logic [7:0]       r_mem_seq [FIFO_DEPTH];

    logic [3:0] w_pressed;
    logic [3:0] w_rise;
    logic [3:0] w_sel;
    logic [1:0] w_sel_idx;
    logic       w_push_req;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       w_ovf_clr_rise;
    logic [1:0] w_head_idx;
    logic [7:0] w_head_seq;
    logic [3:0] w_count4;

    assign w_pressed      = ~r_sync2;
    assign w_rise         = r_stable & ~r_stable_d;
    assign w_push_req     = |r_pending;
    assign w_empty        = (r_count == '0);
    assign w_full         = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_pop          = (io_bus.ack_toggle != r_ack_prev) && !w_empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_push         = w_push_req && (!w_full || w_pop);
    assign w_drop         = w_push_req && w_full && !w_pop;
    assign w_ovf_clr_rise = io_bus.ovf_clr && !r_ovf_clr_prev;
    assign w_head_idx     = r_mem_idx[r_rd_ptr];
    assign w_head_seq     = r_mem_seq[r_rd_ptr];
    assign w_count4       = 4'(r_count);
    assign w_sel          = 4'b0001 << w_sel_idx;
    assign io_bus.status  = r_status;

    always_comb begin
        w_sel_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (r_pending[i]) w_sel_idx = 2'(i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync1    <= 4'hF;
            r_sync2    <= 4'hF;
            r_stable   <= 4'h0;
            r_stable_d <= 4'h0;
            for (int i = 0; i < 4; i++) r_db_cnt[i] <= 20'd0;
        end else begin
            r_sync1    <= io_bus.key_n;
            r_sync2    <= r_sync1;
            r_stable_d <= r_stable;
            for (int i = 0; i < 4; i++) begin
                if (w_pressed[i] != r_stable[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_stable[i] <= w_pressed[i];
                        r_db_cnt[i] <= 20'd0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + 20'd1;
                    end
                end else begin
                    r_db_cnt[i] <= 20'd0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pending      <= 4'h0;
            r_seq          <= 8'd0;
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_ovf          <= 1'b0;
            r_ack_prev     <= 1'b0;
            r_ovf_clr_prev <= 1'b0;
            r_status       <= 32'd0;
        end else begin
            // Selected bit clears whether the event is queued or dropped.
            r_pending      <= (r_pending & ~(w_push_req ? w_sel : 4'h0)) | w_rise;
            r_ack_prev     <= io_bus.ack_toggle;
            r_ovf_clr_prev <= io_bus.ovf_clr;
            if (w_push) begin
                r_seq    <= r_seq + 8'd1;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)              r_ovf <= 1'b1;
            else if (w_ovf_clr_rise) r_ovf <= 1'b0;
            r_status <= {12'd0,
                         w_empty ? 8'd0 : w_head_seq,
                         r_stable,
                         r_ovf,
                         w_count4,
                         !w_empty,
                         w_empty ? 2'd0 : w_head_idx};
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_idx[r_wr_ptr] <= w_sel_idx;
            r_mem_seq[r_wr_ptr] <= r_seq;
        end
    end
endmodule
